// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    localparam int          MULDIV_ITER    = 32;
    localparam logic [31:0] MULDIV_DIV0_LO = 32'hFFFF_FFFF;

    // op[0]=0 selects the signed flavour, op[1]=1 selects divide
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate of a W-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: neg (negate when 1), din (input word), dout (din or -din).
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO moves.
// Latency: 34 cycles from accepted start to busy low; done pulses in the last cycle.
// Backpressure: none; start/mthi/mtlo are dropped while busy, no queuing.
// Ports: clk, rst_n, start, op, rsvalue, rtvalue, mthi, mtlo -> busy, done, hi, lo.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsvalue,
    input  logic [WIDTH-1:0] rtvalue,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t      state_q, state_nxt;
    logic [4:0]         cnt_q;
    logic [1:0]         op_q;
    logic               sign_pq_q;   // product / quotient sign
    logic               sign_r_q;    // remainder sign
    logic               div0_q;
    logic [WIDTH-1:0]   opd_q;       // multiplicand (mult) or divisor (div)
    logic [2*WIDTH-1:0] acc_q;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               load_en, iter_en, fix_en, move_en;
    logic               is_signed;
    logic [WIDTH-1:0]   mag_rs, mag_rt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // ---------------- operand magnitudes ----------------
    assign is_signed = op_is_signed(op);

    muldiv_signfix #(.W(WIDTH)) u_mag_rs (
        .neg  (is_signed & rsvalue[WIDTH-1]),
        .din  (rsvalue),
        .dout (mag_rs)
    );

    muldiv_signfix #(.W(WIDTH)) u_mag_rt (
        .neg  (is_signed & rtvalue[WIDTH-1]),
        .din  (rtvalue),
        .dout (mag_rt)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt_q == 5'(MULDIV_ITER - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: control strobes ----------------
    always_comb begin
        load_en = 1'b0;
        iter_en = 1'b0;
        fix_en  = 1'b0;
        move_en = 1'b0;
        case (state_q)
            IDLE: begin
                load_en = start;
                move_en = ~start;   // start wins over a simultaneous move
            end
            RUN:     iter_en = 1'b1;
            FIX:     fix_en  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- one iteration step ----------------
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the 65-bit result right.
    logic [WIDTH:0]     mul_sum;
    // Restoring divide: shift remainder left taking the next dividend bit,
    // trial-subtract the divisor, keep the difference if it did not borrow.
    logic [WIDTH:0]     div_top;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = {1'b0, div_top} - {2'b00, opd_q};
    assign div_ok   = ~div_diff[WIDTH+1];
    // Remainder stays below the divisor, so the top bit is always zero here.
    assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0];
    assign acc_step = op_is_div(op_q) ? {div_rem, acc_q[WIDTH-2:0], div_ok}
                                      : {mul_sum, acc_q[WIDTH-1:1]};

    // ---------------- result sign correction ----------------
    muldiv_signfix #(.W(2*WIDTH)) u_prod_fix (
        .neg  (sign_pq_q),
        .din  (acc_q),
        .dout (prod_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_quot_fix (
        .neg  (sign_pq_q),
        .din  (acc_q[WIDTH-1:0]),
        .dout (quot_fix)
    );

    // A zero divisor leaves the dividend magnitude in the remainder, so this
    // path already yields the original rsvalue for HI.
    muldiv_signfix #(.W(WIDTH)) u_rem_fix (
        .neg  (sign_r_q),
        .din  (acc_q[2*WIDTH-1:WIDTH]),
        .dout (rem_fix)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            sign_pq_q <= 1'b0;
            sign_r_q  <= 1'b0;
            div0_q    <= 1'b0;
            opd_q     <= '0;
            acc_q     <= '0;
        end else if (load_en) begin
            cnt_q     <= '0;
            op_q      <= op;
            sign_pq_q <= is_signed & (rsvalue[WIDTH-1] ^ rtvalue[WIDTH-1]);
            sign_r_q  <= is_signed & rsvalue[WIDTH-1];
            div0_q    <= op_is_div(op) && (rtvalue == '0);
            opd_q     <= op_is_div(op) ? mag_rt : mag_rs;
            acc_q     <= {{WIDTH{1'b0}}, (op_is_div(op) ? mag_rs : mag_rt)};
        end else if (iter_en) begin
            cnt_q     <= cnt_q + 5'd1;
            acc_q     <= acc_step;
        end
    end

    // ---------------- HI / LO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_en) begin
            if (op_is_div(op_q)) begin
                hi_q <= rem_fix;
                lo_q <= div0_q ? MULDIV_DIV0_LO : quot_fix;
            end else begin
                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                lo_q <= prod_fix[WIDTH-1:0];
            end
        end else if (move_en) begin
            if (mthi) hi_q <= rsvalue;
            if (mtlo) lo_q <= rsvalue;
        end
    end

    // ---------------- registered status outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MicroMIPS datapath. It sits directly downstream of the register file and takes the two operand words read from `rs` and `rt`. It runs MULT/MULTU/DIV/DIVU over multiple cycles behind a start/busy/done handshake. HI and LO are always visible for MFHI/MFLO selection into the writeback mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the only supported value is 32.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rsvalue`  in  32  first operand (multiplicand or dividend), from the register file.
- `rtvalue`  in  32  second operand (multiplier or divisor), from the register file's unmuxed rt port.
- `mthi`  in  1  write `rsvalue` into HI.
- `mtlo`  in  1  write `rsvalue` into LO.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accepts `start`, `mthi`, `mtlo`.
  - RUN: 32 iterations, 5-bit counter.
  - FIX: sign correction and HI/LO write.
  - DONE: asserts `done`, then returns to IDLE.
- Launch:
  - In IDLE, a `start` edge latches `op`.
  - Magnitudes of both operands are latched: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - The result signs are latched: product/quotient sign = rs[31]^rt[31]; remainder sign = rs[31]. Both are forced to 0 for unsigned ops.
- Multiply: shift-add over 32 RUN cycles into a 64-bit accumulator. FIX negates the 64-bit value if the sign is set, then writes HI = [63:32] and LO = [31:0].
- Divide: restoring divide over 32 RUN cycles. FIX applies the quotient sign to LO and the remainder sign to HI.
- Divide by zero: full latency; LO = 32'hFFFF_FFFF, HI = dividend (original `rsvalue`, unsigned view).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and needs no special-casing.
- `mthi`/`mtlo` in IDLE: the named register takes `rsvalue` at the edge, with no other effect.
- Operation priority in IDLE: if `start` and `mthi`/`mtlo` are asserted in the same cycle, `start` wins and the moves are dropped.
- Ignored inputs: `start`, `mthi` and `mtlo` are ignored in RUN, FIX and DONE. There is no queuing.
- HI/LO hold their old values throughout RUN. They change only at the FIX→DONE edge or on a move.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, accumulators=0.
- Start sequence (accepted at edge E0):
  - `busy`=1 from E0 through E34, i.e. E0 plus 34 cycles.
  - RUN spans edges E1–E32.
  - FIX writes HI/LO at E33.
  - `done`=1 for exactly the cycle E33–E34, with the new `hi`/`lo` already valid in that cycle.
  - State returns to IDLE at E34, with `busy`=0.
- Fixed latency: 34 cycles from accept to `busy` deassertion, independent of operand values.
- Back-to-back: a `start` in the cycle after `done` (IDLE at E34) is accepted.
- Operand stability: operands are sampled only at the accept edge. `rsvalue`/`rtvalue` may change freely afterwards.
- Reset mid-operation: `rst_n` low forces the reset values immediately (asynchronously). A partial result is discarded, and HI/LO read 0.
- Combinational paths: no input-to-output combinational path; all outputs are registered.

## Structure
- Shared package `muldiv_pkg`:
  - `op` encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State enum `muldiv_state_t` (IDLE, RUN, FIX, DONE).
  - `MULDIV_ITER` = 32.
  - `MULDIV_DIV0_LO` = 32'hFFFF_FFFF.
- One sub-module, `muldiv_signfix`: a combinational conditional two's-complement negate, parameterised by width. It is instantiated at width 32 for operand magnitudes and remainder/quotient, and at width 64 for the product.
- Sizing: controller, datapath and sub-module together come to roughly 200–300 lines.

## Test plan
- MULT, rs=0xFFFFFFFD (−3), rt=7 → after 34 cycles: `done` pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21); `busy` high for exactly 34 cycles.
- MULTU, rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU, rs=100, rt=7 → LO=14, HI=2.
- Boundary cases:
  - DIVU rs=0x1234, rt=0 → LO=0xFFFFFFFF, HI=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Busy handling:
  - During RUN, assert `start` with new operands and `mthi`=1 → both ignored; the original result lands.
  - In IDLE, `mtlo` with rs=0xA5A5A5A5 → LO=0xA5A5A5A5 next cycle; `done` stays 0.
- Reset and back-to-back:
  - Pull `rst_n` low at RUN iteration 16 → `busy`, `done`, `hi`, `lo` all 0 immediately.
  - After release, a new MULTU 3×5 completes with LO=15 at the nominal latency.
  - A `start` issued the cycle after `done` is accepted.
